// File: rtl/bitscan_encoder.sv
// Registered one-hot / priority-scan encoder: captures a request vector and emits one
// binary index per handshake, either checking strict one-hot or walking every set bit.
module bitscan_encoder #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned CW       = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] req_in,
  input  logic             code_ready,
  output logic [CW-1:0]    code_out,
  output logic             code_valid,
  output logic             last,
  output logic             none,
  output logic             error,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StEmit} state_t;

  typedef struct packed {
    logic          last;
    logic          none;
    logic          error;
    logic [CW-1:0] code;
  } beat_t;

  localparam beat_t IdleBeat = '{last: 1'b0, none: 1'b0, error: 1'b0, code: '1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             mode_q, mode_d;
  beat_t            beat_q, beat_d;

  // Describes the beat presented for a given pending vector; m=0 strict, m=1 scan.
  function automatic beat_t encode(input logic [WIDTH-1:0] p, input logic m);
    beat_t         b;
    logic [CW-1:0] idx;
    logic          one;
    idx = '1;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (p[i]) idx = CW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (p[i]) idx = CW'(i);
      end
    end
    one = (p != '0) && ((p & (p - WIDTH'(1))) == '0);
    b   = IdleBeat;
    if (p == '0) begin
      b.last  = 1'b1;
      b.none  = 1'b1;
      b.error = ~m;
    end else if (!m) begin
      b.last  = 1'b1;
      b.error = ~one;
      b.code  = one ? idx : '1;
    end else begin
      b.last = one;
      b.code = idx;
    end
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    beat_d    = beat_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          pending_d = req_in;
          mode_d    = mode;
          beat_d    = encode(req_in, mode);
          state_d   = StEmit;
        end
      end
      StEmit: begin
        if (code_ready) begin
          if (beat_q.last) begin
            pending_d = '0;
            beat_d    = IdleBeat;
            state_d   = StIdle;
          end else begin
            // Non-last beats only occur in scan mode, so code is a real index here.
            pending_d[beat_q.code] = 1'b0;
            beat_d = encode(pending_d, mode_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= StIdle;
      pending_q <= '0;
      mode_q    <= 1'b0;
      beat_q    <= IdleBeat;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      beat_q    <= beat_d;
    end
  end

  assign code_out   = beat_q.code;
  assign last       = beat_q.last;
  assign none       = beat_q.none;
  assign error      = beat_q.error;
  assign code_valid = (state_q == StEmit);
  assign busy       = (state_q == StEmit);

endmodule

// File: tb/tb_bitscan_encoder.sv
// Directed bench for bitscan_encoder: an LSB-first and an MSB-first instance share the
// stimulus; expected beats are queued per instance and checked as each handshake occurs.
module tb_bitscan_encoder;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = 5;

  logic             clock = 1'b0;
  logic             clear = 1'b1;
  logic             load = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] req_in = '0;
  logic             code_ready = 1'b1;

  logic [CW-1:0] code0, code1;
  logic          valid0, valid1, last0, last1, none0, none1, err0, err1, busy0, busy1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Beat packed as {last, none, error, code}.
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clock = ~clock;

  bitscan_encoder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut0 (
    .clock(clock), .clear(clear), .load(load), .mode(mode), .req_in(req_in),
    .code_ready(code_ready), .code_out(code0), .code_valid(valid0), .last(last0),
    .none(none0), .error(err0), .busy(busy0)
  );

  bitscan_encoder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut1 (
    .clock(clock), .clear(clear), .load(load), .mode(mode), .req_in(req_in),
    .code_ready(code_ready), .code_out(code1), .code_valid(valid1), .last(last1),
    .none(none1), .error(err1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] bt(input logic l, input logic n, input logic e,
                                    input logic [4:0] c);
    return {l, n, e, c};
  endfunction

  // Compares the beat about to complete on the next edge against the scoreboard.
  task automatic check_beats();
    logic [7:0] e;
    if (valid0 && code_ready) begin
      if (q0.size() == 0) chk("dut0 underflow", q0.size(), 1);
      else begin
        e = q0.pop_front();
        chk("dut0 beat", {last0, none0, err0, code0}, e);
      end
    end
    if (valid1 && code_ready) begin
      if (q1.size() == 0) chk("dut1 underflow", q1.size(), 1);
      else begin
        e = q1.pop_front();
        chk("dut1 beat", {last1, none1, err1, code1}, e);
      end
    end
  endtask

  task automatic cyc();
    check_beats();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy0"}, busy0, 0);
    chk({tag, " busy1"}, busy1, 0);
    chk({tag, " valid0"}, valid0, 0);
    chk({tag, " valid1"}, valid1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: clear asserted mid-scan, checked before any edge
    #12 clear = 1'b0;
    @(posedge clock); #1;
    mode = 1'b1; req_in = 32'h8000_0011; load = 1'b1; code_ready = 1'b0;
    cyc();
    load = 1'b0;
    chk("t1 busy before clear", busy0, 1);
    #2 clear = 1'b1;
    #1;
    chk("t1 code0", code0, 31);
    chk("t1 code1", code1, 31);
    chk("t1 flags0", {valid0, busy0, last0, none0, err0}, 0);
    chk("t1 flags1", {valid1, busy1, last1, none1, err1}, 0);
    @(posedge clock); #1;
    clear = 1'b0; code_ready = 1'b1;

    // 2: strict one-hot
    mode = 1'b0; req_in = 32'h0000_0400; load = 1'b1;
    q0.push_back(bt(1, 0, 0, 10)); q1.push_back(bt(1, 0, 0, 10));
    cyc();
    load = 1'b0;
    chk("t2 valid after load", valid0, 1);
    chk("t2 busy after load", busy1, 1);
    cyc();
    chk_idle("t2");

    // 3: strict violations, two bits then zero
    req_in = 32'h0000_0006; load = 1'b1;
    q0.push_back(bt(1, 0, 1, 31)); q1.push_back(bt(1, 0, 1, 31));
    cyc();
    load = 1'b0;
    cyc();
    chk_idle("t3a");
    req_in = 32'h0; load = 1'b1;
    q0.push_back(bt(1, 1, 1, 31)); q1.push_back(bt(1, 1, 1, 31));
    cyc();
    load = 1'b0;
    cyc();
    chk_idle("t3b");

    // 4: scan, back-to-back beats
    mode = 1'b1; req_in = 32'h8000_0011; load = 1'b1;
    q0.push_back(bt(0, 0, 0, 0)); q0.push_back(bt(0, 0, 0, 4)); q0.push_back(bt(1, 0, 0, 31));
    q1.push_back(bt(0, 0, 0, 31)); q1.push_back(bt(0, 0, 0, 4)); q1.push_back(bt(1, 0, 0, 0));
    cyc();
    load = 1'b0;
    repeat (3) cyc();
    chk_idle("t4");
    chk("t4 q0 drained", q0.size(), 0);
    chk("t4 q1 drained", q1.size(), 0);

    // 5: scan with backpressure and a load ignored while busy
    req_in = 32'h8000_0011; load = 1'b1;
    q0.push_back(bt(0, 0, 0, 0)); q0.push_back(bt(0, 0, 0, 4)); q0.push_back(bt(1, 0, 0, 31));
    q1.push_back(bt(0, 0, 0, 31)); q1.push_back(bt(0, 0, 0, 4)); q1.push_back(bt(1, 0, 0, 0));
    cyc();
    load = 1'b0;
    cyc();
    code_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load = (i == 1); req_in = 32'hFFFF_FFFF;
      chk("t5 held code0", code0, 4);
      chk("t5 held code1", code1, 4);
      cyc();
    end
    load = 1'b0; code_ready = 1'b1;
    cyc();
    cyc();
    chk_idle("t5");
    chk("t5 q0 drained", q0.size(), 0);
    chk("t5 q1 drained", q1.size(), 0);

    // 6: clear after the second beat, then a fresh single-bit scan
    req_in = 32'h0000_F000; load = 1'b1;
    q0.push_back(bt(0, 0, 0, 12)); q0.push_back(bt(0, 0, 0, 13));
    q1.push_back(bt(0, 0, 0, 15)); q1.push_back(bt(0, 0, 0, 14));
    cyc();
    load = 1'b0;
    cyc();
    cyc();
    clear = 1'b1;
    #1;
    chk_idle("t6 clear");
    chk("t6 code0 cleared", code0, 31);
    @(posedge clock); #1;
    clear = 1'b0;
    req_in = 32'h0000_0001; load = 1'b1;
    q0.push_back(bt(1, 0, 0, 0)); q1.push_back(bt(1, 0, 0, 0));
    cyc();
    load = 1'b0;
    cyc();
    chk_idle("t6 end");
    chk("t6 q0 drained", q0.size(), 0);
    chk("t6 q1 drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
